// File: rtl/phase1_pkg.sv
// Shared constants for the Mini SRC phase-1 datapath: the data width and the
// ALUControl opcode values.
package phase1_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_MUL  = 5'b00010;
    localparam logic [4:0] ALU_DIV  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00100;
    localparam logic [4:0] ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_SHR  = 5'b00110;
    localparam logic [4:0] ALU_SHRA = 5'b00111;
    localparam logic [4:0] ALU_SHL  = 5'b01000;
    localparam logic [4:0] ALU_ROR  = 5'b01001;
    localparam logic [4:0] ALU_ROL  = 5'b01010;
    localparam logic [4:0] ALU_NEG  = 5'b01011;
    localparam logic [4:0] ALU_NOT  = 5'b01100;

endpackage

// File: rtl/phase1_datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus, and the 64-bit result
// feeds Z. Only MUL and DIV produce a nonzero high word.
module alu
    import phase1_pkg::*;
(
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [4:0]          op_i,
    output logic [2*DATA_W-1:0] c_o
);

    logic [4:0]            shamt;
    logic [2*DATA_W-1:0]   doubled;
    logic [2*DATA_W-1:0]   rorWide;
    logic [2*DATA_W-1:0]   rolWide;
    logic signed [DATA_W-1:0] quot;
    logic signed [DATA_W-1:0] rem;

    assign shamt   = b_i[4:0];
    assign doubled = {a_i, a_i};
    assign rorWide = doubled >> shamt;
    assign rolWide = doubled << shamt;

    // Divide by zero must return zero rather than whatever the operator yields.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (b_i != '0) begin
            quot = $signed(a_i) / $signed(b_i);
            rem  = $signed(a_i) % $signed(b_i);
        end
    end

    always_comb begin
        c_o = '0;
        case (op_i)
            ALU_ADD:  c_o[DATA_W-1:0] = a_i + b_i;
            ALU_SUB:  c_o[DATA_W-1:0] = a_i - b_i;
            ALU_MUL:  c_o = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                            $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
            ALU_DIV:  c_o = {rem, quot};
            ALU_AND:  c_o[DATA_W-1:0] = a_i & b_i;
            ALU_OR:   c_o[DATA_W-1:0] = a_i | b_i;
            ALU_SHR:  c_o[DATA_W-1:0] = a_i >> shamt;
            ALU_SHRA: c_o[DATA_W-1:0] = $signed(a_i) >>> shamt;
            ALU_SHL:  c_o[DATA_W-1:0] = a_i << shamt;
            ALU_ROR:  c_o[DATA_W-1:0] = rorWide[DATA_W-1:0];
            ALU_ROL:  c_o[DATA_W-1:0] = rolWide[2*DATA_W-1:DATA_W];
            ALU_NEG:  c_o[DATA_W-1:0] = -b_i;
            ALU_NOT:  c_o[DATA_W-1:0] = ~b_i;
            default:  c_o = '0;
        endcase
    end

endmodule

// File: rtl/phase1_datapath.sv
// Phase-1 Mini SRC datapath: one shared bus, general registers R6/R7, the
// special registers and the ALU, all sequenced externally cycle by cycle.
module phase1_datapath
    import phase1_pkg::*;
(
    input  logic              Clock,
    input  logic              Clear,
    input  logic              R6in,
    input  logic              R7in,
    input  logic              PCin,
    input  logic              IRin,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Yin,
    input  logic              Zin,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              R6out,
    input  logic              R7out,
    input  logic              PCout,
    input  logic              MDRout,
    input  logic              ZHIout,
    input  logic              ZLOout,
    input  logic              IncrementPC,
    input  logic              Read,
    input  logic [4:0]        ALUControl,
    input  logic [DATA_W-1:0] Mdatain,
    output logic [DATA_W-1:0] big_boy_bus,
    output logic [DATA_W-1:0] R6_data_out,
    output logic [DATA_W-1:0] R7_data_out,
    output logic [DATA_W-1:0] Y_data_out,
    output logic [DATA_W-1:0] HI_data_out,
    output logic [DATA_W-1:0] LO_data_out,
    output logic [DATA_W-1:0] MDR_data_out,
    output logic [DATA_W-1:0] MDR_data_in,
    output logic [DATA_W-1:0] Z_data_out
);

    logic [DATA_W-1:0]   r6Q, r7Q, pcQ, irQ, marQ, mdrQ, yQ, hiQ, loQ;
    logic [2*DATA_W-1:0] zQ;
    logic [DATA_W-1:0]   pcD;
    logic [DATA_W-1:0]   mdrD;
    logic [2*DATA_W-1:0] zD;
    logic [DATA_W-1:0]   bus;

    // Several selects at once is a sequencer bug; priority keeps the bus defined.
    always_comb begin
        bus = '0;
        if (ZHIout)      bus = zQ[2*DATA_W-1:DATA_W];
        else if (ZLOout) bus = zQ[DATA_W-1:0];
        else if (MDRout) bus = mdrQ;
        else if (PCout)  bus = pcQ;
        else if (R7out)  bus = r7Q;
        else if (R6out)  bus = r6Q;
    end

    assign mdrD = Read ? Mdatain : bus;
    assign pcD  = IncrementPC ? pcQ + DATA_W'(1) : bus;

    alu uAlu (
        .a_i  (yQ),
        .b_i  (bus),
        .op_i (ALUControl),
        .c_o  (zD)
    );

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r6Q  <= '0;
            r7Q  <= '0;
            pcQ  <= '0;
            irQ  <= '0;
            marQ <= '0;
            mdrQ <= '0;
            yQ   <= '0;
            zQ   <= '0;
            hiQ  <= '0;
            loQ  <= '0;
        end else begin
            if (R6in)  r6Q  <= bus;
            if (R7in)  r7Q  <= bus;
            if (PCin)  pcQ  <= pcD;
            if (IRin)  irQ  <= bus;
            if (MARin) marQ <= bus;
            if (MDRin) mdrQ <= mdrD;
            if (Yin)   yQ   <= bus;
            if (Zin)   zQ   <= zD;
            if (HIin)  hiQ  <= bus;
            if (LOin)  loQ  <= bus;
        end
    end

    assign big_boy_bus  = bus;
    assign R6_data_out  = r6Q;
    assign R7_data_out  = r7Q;
    assign Y_data_out   = yQ;
    assign HI_data_out  = hiQ;
    assign LO_data_out  = loQ;
    assign MDR_data_out = mdrQ;
    assign MDR_data_in  = mdrD;
    assign Z_data_out   = zQ[DATA_W-1:0];

endmodule

// File: tb/tb_phase1_datapath.sv
// Directed-vector bench for phase1_datapath: drives control words cycle by
// cycle and compares register contents against hand-computed values.
module tb_phase1_datapath;
    import phase1_pkg::*;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        R6in, R7in, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic        R6out, R7out, PCout, MDRout, ZHIout, ZLOout;
    logic        IncrementPC, Read;
    logic [4:0]  ALUControl;
    logic [31:0] Mdatain;
    logic [31:0] big_boy_bus, R6_data_out, R7_data_out, Y_data_out;
    logic [31:0] HI_data_out, LO_data_out, MDR_data_out, MDR_data_in, Z_data_out;

    int checkCount = 0;
    int passCount  = 0;

    phase1_datapath dut (
        .Clock(Clock), .Clear(Clear),
        .R6in(R6in), .R7in(R7in), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .R6out(R6out), .R7out(R7out), .PCout(PCout), .MDRout(MDRout),
        .ZHIout(ZHIout), .ZLOout(ZLOout),
        .IncrementPC(IncrementPC), .Read(Read), .ALUControl(ALUControl),
        .Mdatain(Mdatain), .big_boy_bus(big_boy_bus),
        .R6_data_out(R6_data_out), .R7_data_out(R7_data_out),
        .Y_data_out(Y_data_out), .HI_data_out(HI_data_out),
        .LO_data_out(LO_data_out), .MDR_data_out(MDR_data_out),
        .MDR_data_in(MDR_data_in), .Z_data_out(Z_data_out)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    task automatic clearCtrl();
        {R6in, R7in, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin} = '0;
        {R6out, R7out, PCout, MDRout, ZHIout, ZLOout} = '0;
        IncrementPC = 1'b0;
        Read        = 1'b0;
        ALUControl  = ALU_ADD;
    endtask

    // Controls are set just after an edge, so the next edge is the one that loads.
    task automatic applyStimulus();
        @(posedge Clock);
        #1;
        clearCtrl();
    endtask

    task automatic loadMdr(input logic [31:0] value);
        Mdatain = value; Read = 1'b1; MDRin = 1'b1;
        applyStimulus();
    endtask

    task automatic loadY(input logic [31:0] value);
        loadMdr(value);
        MDRout = 1'b1; Yin = 1'b1;
        applyStimulus();
    endtask

    task automatic aluOp(input logic [31:0] bValue, input logic [4:0] op);
        loadMdr(bValue);
        MDRout = 1'b1; ALUControl = op; Zin = 1'b1;
        applyStimulus();
    endtask

    task automatic zToHiLo();
        ZLOout = 1'b1; LOin = 1'b1;
        applyStimulus();
        ZHIout = 1'b1; HIin = 1'b1;
        applyStimulus();
    endtask

    initial begin
        clearCtrl();
        Mdatain = '0;
        Clear   = 1'b0;
        #12;
        checkOutput("reset_r6", R6_data_out, 32'h0);
        checkOutput("reset_z", Z_data_out, 32'h0);
        checkOutput("reset_bus", big_boy_bus, 32'h0);
        Clear = 1'b1;
        #2;

        Mdatain = 32'h12; Read = 1'b1; MDRin = 1'b1;
        #1 checkOutput("mdr_in_mux", MDR_data_in, 32'h12);
        applyStimulus();
        checkOutput("mdr_load", MDR_data_out, 32'h12);
        MDRout = 1'b1; R6in = 1'b1;
        applyStimulus();
        checkOutput("r6_load", R6_data_out, 32'h12);
        loadMdr(32'h14);
        MDRout = 1'b1; R7in = 1'b1;
        applyStimulus();
        checkOutput("r7_load", R7_data_out, 32'h14);

        R6out = 1'b1; Yin = 1'b1;
        applyStimulus();
        checkOutput("y_from_r6", Y_data_out, 32'h12);
        R7out = 1'b1; ALUControl = ALU_MUL; Zin = 1'b1;
        applyStimulus();
        checkOutput("mul_z", Z_data_out, 32'h168);
        zToHiLo();
        checkOutput("mul_lo", LO_data_out, 32'h168);
        checkOutput("mul_hi", HI_data_out, 32'h0);

        loadMdr(32'hFFFF_FFFF);
        MDRout = 1'b1; R6in = 1'b1;
        applyStimulus();
        loadMdr(32'h2);
        MDRout = 1'b1; R7in = 1'b1;
        applyStimulus();
        R6out = 1'b1; Yin = 1'b1;
        applyStimulus();
        R7out = 1'b1; ALUControl = ALU_MUL; Zin = 1'b1;
        applyStimulus();
        zToHiLo();
        checkOutput("mul_neg_lo", LO_data_out, 32'hFFFF_FFFE);
        checkOutput("mul_neg_hi", HI_data_out, 32'hFFFF_FFFF);

        PCout = 1'b1; Yin = 1'b1;
        applyStimulus();
        PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALUControl = ALU_ADD;
        applyStimulus();
        checkOutput("fetch_z", Z_data_out, 32'h0);
        checkOutput("fetch_mar", dut.marQ, 32'h0);
        PCin = 1'b1; IncrementPC = 1'b1; Read = 1'b1; MDRin = 1'b1;
        Mdatain = 32'h2891_8000;
        applyStimulus();
        PCout = 1'b1;
        #1 checkOutput("fetch_pc_inc", big_boy_bus, 32'h1);
        clearCtrl();
        checkOutput("fetch_mdr", MDR_data_out, 32'h2891_8000);
        MDRout = 1'b1; IRin = 1'b1;
        applyStimulus();
        checkOutput("fetch_ir", dut.irQ, 32'h2891_8000);

        loadY(32'd20);
        aluOp(32'd6, ALU_DIV);
        zToHiLo();
        checkOutput("div_lo", LO_data_out, 32'd3);
        checkOutput("div_hi", HI_data_out, 32'd2);
        ALUControl = ALU_DIV; Zin = 1'b1;
        applyStimulus();
        zToHiLo();
        checkOutput("div0_lo", LO_data_out, 32'h0);
        checkOutput("div0_hi", HI_data_out, 32'h0);
        loadY(32'hFFFF_FFF9);
        aluOp(32'd2, ALU_DIV);
        zToHiLo();
        checkOutput("div_neg_lo", LO_data_out, 32'hFFFF_FFFD);
        checkOutput("div_neg_hi", HI_data_out, 32'hFFFF_FFFF);

        loadY(32'h0000_F0F0);
        aluOp(32'h00FF_00FF, ALU_AND);
        checkOutput("and_z", Z_data_out, 32'h0000_00F0);
        aluOp(32'h00FF_00FF, ALU_OR);
        checkOutput("or_z", Z_data_out, 32'h00FF_F0FF);
        loadY(32'h8000_0000);
        aluOp(32'd4, ALU_SHRA);
        checkOutput("shra_z", Z_data_out, 32'hF800_0000);
        aluOp(32'd4, ALU_SHR);
        checkOutput("shr_z", Z_data_out, 32'h0800_0000);
        loadY(32'h8000_0001);
        aluOp(32'd4, ALU_ROL);
        checkOutput("rol_z", Z_data_out, 32'h0000_0018);
        aluOp(32'd4, ALU_ROR);
        checkOutput("ror_z", Z_data_out, 32'h1800_0000);
        aluOp(32'h24, ALU_SHL);
        checkOutput("shl_z", Z_data_out, 32'h0000_0010);
        loadY(32'd5);
        aluOp(32'd7, ALU_SUB);
        checkOutput("sub_wrap_z", Z_data_out, 32'hFFFF_FFFE);
        aluOp(32'd7, ALU_NEG);
        checkOutput("neg_z", Z_data_out, 32'hFFFF_FFF9);
        aluOp(32'h0F0F_0000, ALU_NOT);
        checkOutput("not_z", Z_data_out, 32'hF0F0_FFFF);
        aluOp(32'd7, 5'b11111);
        checkOutput("bad_op_z", Z_data_out, 32'h0);

        R6out = 1'b1; ZLOout = 1'b1;
        #1 checkOutput("bus_priority", big_boy_bus, 32'h0);
        clearCtrl();
        #1 checkOutput("bus_idle", big_boy_bus, 32'h0);

        loadY(32'h55);
        #2 Clear = 1'b0;
        #1;
        checkOutput("clr_r6", R6_data_out, 32'h0);
        checkOutput("clr_r7", R7_data_out, 32'h0);
        checkOutput("clr_y", Y_data_out, 32'h0);
        checkOutput("clr_hi", HI_data_out, 32'h0);
        checkOutput("clr_lo", LO_data_out, 32'h0);
        checkOutput("clr_mdr", MDR_data_out, 32'h0);
        checkOutput("clr_z", Z_data_out, 32'h0);
        checkOutput("clr_pc", dut.pcQ, 32'h0);
        checkOutput("clr_ir", dut.irQ, 32'h0);
        Clear = 1'b1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
